axi_rd_wr_arbiter_2to1: RTL and testbench
=========================================

# axi_rd_wr_arbiter_2to1

Two-master, one-slave AXI3 arbiter that merges the instruction-cache and data-cache AXI master ports into the single CPU AXI port of `mycpu_top`. It replaces the vendor crossbar IP. It sits directly downstream of `icache` (port s0) and `dcache` (port s1), and drives the top-level AR/R/AW/W/B pins. Read and write paths are arbitrated independently, each with one outstanding transaction and the grant held for the whole burst.

## Interface
- `ID_W`, default 4: AXI ID width on all ports.
- `aclk`, in, 1: clock.
- `aresetn`, in, 1: asynchronous, active-low reset.
- `s{0,1}_araddr`, in, 32: read address from master 0 (icache) or master 1 (dcache).
- `s{0,1}_arlen` / `arsize`, in, 8 / 3: read burst length and size.
- `s{0,1}_arvalid`, in, 1: read address valid. `s{0,1}_arready`, out, 1: read address accepted.
- `s{0,1}_rdata` / `rresp` / `rid`, out, 32 / 2 / ID_W: read data, routed from the master port.
- `s{0,1}_rlast` / `rvalid`, out, 1: read last / read valid. `s{0,1}_rready`, in, 1: read ready.
- `s{0,1}_awaddr` / `awlen` / `awsize`, in, 32 / 8 / 3: write address, length, size. `s{0,1}_awvalid`, in, 1. `s{0,1}_awready`, out, 1.
- `s{0,1}_wdata` / `wstrb`, in, 32 / 4. `s{0,1}_wlast` / `wvalid`, in, 1. `s{0,1}_wready`, out, 1.
- `s{0,1}_bresp`, out, 2. `s{0,1}_bvalid`, out, 1. `s{0,1}_bready`, in, 1.
- `m_ar*` / `m_aw*`, out: address, len and size of the granted master; valid; `m_arid` / `m_awid` = grant index, zero-extended.
- `m_arburst` / `m_awburst` = 2'b01. `m_*lock` = 0, `m_*cache` = 0, `m_*prot` = 0. `m_wid` = `m_awid`.
- `m_arready`, `m_awready`, `m_wready`, `m_rvalid`, `m_rlast`, `m_bvalid`, in, 1. `m_rdata`, in, 32. `m_rresp` / `m_bresp`, in, 2. `m_rid` / `m_bid`, in, ID_W (ignored for routing).
- `m_rready`, `m_bready`, `m_wvalid`, `m_wlast`, out, 1. `m_wdata` / `m_wstrb`, out, 32 / 4.

## Operation
- Read FSM: R_IDLE → R_ADDR → R_DATA → R_IDLE. Register `rgnt` holds 0 or 1.
- R_IDLE: if any `s*_arvalid`, latch `rgnt` and go to R_ADDR.
  - Only one request: grant that master.
  - Both request: grant the master *not* granted last time (round-robin). After reset, last-granted = 0, so dcache wins the first tie.
- R_ADDR: `m_ar*` = `s[rgnt]_ar*`; `m_arvalid` = `s[rgnt]_arvalid`; `s[rgnt]_arready` = `m_arready`. On the handshake, go to R_DATA.
- R_DATA: `s[rgnt]_r*` = `m_r*`; `m_rready` = `s[rgnt]_rready`. On `m_rvalid & m_rready & m_rlast`, go to R_IDLE.
- The non-granted master sees `arready` = 0 and `rvalid` = 0.
- Write FSM: W_IDLE → W_ADDR → W_DATA → W_RESP → W_IDLE, with register `wgnt` and the same arbitration rule, keyed on `s*_awvalid`.
  - W_ADDR forwards AW. W_DATA forwards W.
  - W data presented before the AW handshake is held off: `s*_wready` = 0 outside W_DATA.
  - W_DATA leaves on the `wlast` beat handshake. W_RESP forwards B and leaves on `m_bvalid & m_bready`.
- The read and write FSMs run concurrently. A read by s0 and a write by s1 can be in flight in the same cycle.
- The arbiter has no data buffering. All payload paths are combinational muxes selected by the registered grant.

## Timing
- Reset (asynchronous, `aresetn` = 0): both FSMs go to IDLE, and both grants and last-granted registers go to 0.
  - Outputs during and immediately after reset: every valid and ready output = 0, `m_*id` = 0, payload outputs = the mux of port 0.
- Address latency: `s*_arvalid` rising at cycle N gives `m_arvalid` = 1 at N+1. The same applies to AW.
- Data and response paths add zero latency.
- Back-to-back: the earliest next AR grant is the cycle after the `rlast` handshake. The IDLE state costs 1 bubble.
- A master that deasserts `arvalid` in R_ADDR before the handshake violates AXI. No recovery is required; the FSM waits.
- `aresetn` asserted mid-burst aborts immediately with no completion to the masters. Downstream is reset by the same signal.
- `m_rvalid` or `m_bvalid` arriving in a state other than R_DATA / W_RESP is not forwarded, and ready stays 0.

## Test plan
- Single icache read: `s0` AR to 0x1FC0_0000, `arlen` = 7.
  - `m_arvalid` rises 1 cycle later with `m_arid` = 0.
  - 8 beats of R reach `s0`. `s1_rvalid` stays 0.
  - The FSM is back in R_IDLE 1 cycle after `rlast`.
- Simultaneous AR from `s0` and `s1` right after reset: `s1` is granted first. Then `s0` is granted, with a 1-cycle bubble between the two bursts. Rerun the tie: the grants alternate.
- Concurrent traffic: an `s0` read burst of 8 beats overlaps an `s1` single write (`wstrb` = 4'b0011, data 0xDEADBEEF). Both complete, and `m_wdata` and `m_wstrb` match the values sent.
- W before AW: `s1_wvalid` is asserted 3 cycles before `s1_awvalid`. `s1_wready` stays 0 until the AW handshake, then the beat is accepted. `m_wlast` = 1.
- Backpressure: `m_arready` held at 0 for 5 cycles, and `s0_rready` toggled every cycle. There is no early `arready`, no lost beats, and data order is preserved.
- Reset mid-burst: `aresetn` is pulled low at beat 3 of 8. All outputs are 0 in the same cycle. After release, a fresh `s0` read completes normally.

Source files
------------

// File: rtl/axi_rd_wr_arbiter_2to1.sv
// Two-master to one-slave AXI3 arbiter (icache on s0, dcache on s1).
// Independent read/write FSMs, round-robin on tie, grant held per burst.
module axi_rd_wr_arbiter_2to1 #(
  parameter int ID_W = 4
) (
  input  logic            aclk,
  input  logic            aresetn,
  // master 0 (icache)
  input  logic [31:0]     s0_araddr,
  input  logic [7:0]      s0_arlen,
  input  logic [2:0]      s0_arsize,
  input  logic            s0_arvalid,
  output logic            s0_arready,
  output logic [31:0]     s0_rdata,
  output logic [1:0]      s0_rresp,
  output logic [ID_W-1:0] s0_rid,
  output logic            s0_rlast,
  output logic            s0_rvalid,
  input  logic            s0_rready,
  input  logic [31:0]     s0_awaddr,
  input  logic [7:0]      s0_awlen,
  input  logic [2:0]      s0_awsize,
  input  logic            s0_awvalid,
  output logic            s0_awready,
  input  logic [31:0]     s0_wdata,
  input  logic [3:0]      s0_wstrb,
  input  logic            s0_wlast,
  input  logic            s0_wvalid,
  output logic            s0_wready,
  output logic [1:0]      s0_bresp,
  output logic            s0_bvalid,
  input  logic            s0_bready,
  // master 1 (dcache)
  input  logic [31:0]     s1_araddr,
  input  logic [7:0]      s1_arlen,
  input  logic [2:0]      s1_arsize,
  input  logic            s1_arvalid,
  output logic            s1_arready,
  output logic [31:0]     s1_rdata,
  output logic [1:0]      s1_rresp,
  output logic [ID_W-1:0] s1_rid,
  output logic            s1_rlast,
  output logic            s1_rvalid,
  input  logic            s1_rready,
  input  logic [31:0]     s1_awaddr,
  input  logic [7:0]      s1_awlen,
  input  logic [2:0]      s1_awsize,
  input  logic            s1_awvalid,
  output logic            s1_awready,
  input  logic [31:0]     s1_wdata,
  input  logic [3:0]      s1_wstrb,
  input  logic            s1_wlast,
  input  logic            s1_wvalid,
  output logic            s1_wready,
  output logic [1:0]      s1_bresp,
  output logic            s1_bvalid,
  input  logic            s1_bready,
  // slave side (CPU AXI port)
  output logic [ID_W-1:0] m_arid,
  output logic [31:0]     m_araddr,
  output logic [7:0]      m_arlen,
  output logic [2:0]      m_arsize,
  output logic [1:0]      m_arburst,
  output logic [1:0]      m_arlock,
  output logic [3:0]      m_arcache,
  output logic [2:0]      m_arprot,
  output logic            m_arvalid,
  input  logic            m_arready,
  input  logic [ID_W-1:0] m_rid,
  input  logic [31:0]     m_rdata,
  input  logic [1:0]      m_rresp,
  input  logic            m_rlast,
  input  logic            m_rvalid,
  output logic            m_rready,
  output logic [ID_W-1:0] m_awid,
  output logic [31:0]     m_awaddr,
  output logic [7:0]      m_awlen,
  output logic [2:0]      m_awsize,
  output logic [1:0]      m_awburst,
  output logic [1:0]      m_awlock,
  output logic [3:0]      m_awcache,
  output logic [2:0]      m_awprot,
  output logic            m_awvalid,
  input  logic            m_awready,
  output logic [ID_W-1:0] m_wid,
  output logic [31:0]     m_wdata,
  output logic [3:0]      m_wstrb,
  output logic            m_wlast,
  output logic            m_wvalid,
  input  logic            m_wready,
  input  logic [ID_W-1:0] m_bid,
  input  logic [1:0]      m_bresp,
  input  logic            m_bvalid,
  output logic            m_bready
);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  logic [1:0] rstate;
  logic       rgnt;
  logic       rlast_gnt;
  logic [1:0] wstate;
  logic       wgnt;
  logic       wlast_gnt;

  logic rpick;
  logic wpick;
  logic r_addr;
  logic r_data;
  logic w_addr;
  logic w_data;
  logic w_resp;

  // B carries no routing information; the id is deliberately dropped.
  logic unused_bid;
  assign unused_bid = ^m_bid;

  // On a tie the master not granted last time wins.
  assign rpick = (s0_arvalid & s1_arvalid) ? ~rlast_gnt : s1_arvalid;
  assign wpick = (s0_awvalid & s1_awvalid) ? ~wlast_gnt : s1_awvalid;

  assign r_addr = (rstate == R_ADDR);
  assign r_data = (rstate == R_DATA);
  assign w_addr = (wstate == W_ADDR);
  assign w_data = (wstate == W_DATA);
  assign w_resp = (wstate == W_RESP);

  // Read FSM: grant latched in idle, held until the last R beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rstate    <= R_IDLE;
      rgnt      <= 1'b0;
      rlast_gnt <= 1'b0;
    end else begin
      unique case (rstate)
        R_IDLE: begin
          if (s0_arvalid | s1_arvalid) begin
            rgnt      <= rpick;
            rlast_gnt <= rpick;
            rstate    <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (m_arvalid & m_arready)
            rstate <= R_DATA;
        end
        R_DATA: begin
          if (m_rvalid & m_rready & m_rlast)
            rstate <= R_IDLE;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // Write FSM: grant held through AW, all W beats and the B response.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wstate    <= W_IDLE;
      wgnt      <= 1'b0;
      wlast_gnt <= 1'b0;
    end else begin
      unique case (wstate)
        W_IDLE: begin
          if (s0_awvalid | s1_awvalid) begin
            wgnt      <= wpick;
            wlast_gnt <= wpick;
            wstate    <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (m_awvalid & m_awready)
            wstate <= W_DATA;
        end
        W_DATA: begin
          if (m_wvalid & m_wready & m_wlast)
            wstate <= W_RESP;
        end
        W_RESP: begin
          if (m_bvalid & m_bready)
            wstate <= W_IDLE;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  assign m_arid    = {{(ID_W-1){1'b0}}, rgnt};
  assign m_araddr  = rgnt ? s1_araddr : s0_araddr;
  assign m_arlen   = rgnt ? s1_arlen  : s0_arlen;
  assign m_arsize  = rgnt ? s1_arsize : s0_arsize;
  assign m_arburst = 2'b01;
  assign m_arlock  = 2'b00;
  assign m_arcache = 4'b0000;
  assign m_arprot  = 3'b000;
  assign m_arvalid = r_addr & (rgnt ? s1_arvalid : s0_arvalid);
  assign s0_arready = r_addr & ~rgnt & m_arready;
  assign s1_arready = r_addr &  rgnt & m_arready;

  assign s0_rdata  = m_rdata;
  assign s0_rresp  = m_rresp;
  assign s0_rid    = m_rid;
  assign s0_rlast  = m_rlast;
  assign s1_rdata  = m_rdata;
  assign s1_rresp  = m_rresp;
  assign s1_rid    = m_rid;
  assign s1_rlast  = m_rlast;
  assign s0_rvalid = r_data & ~rgnt & m_rvalid;
  assign s1_rvalid = r_data &  rgnt & m_rvalid;
  assign m_rready  = r_data & (rgnt ? s1_rready : s0_rready);

  assign m_awid    = {{(ID_W-1){1'b0}}, wgnt};
  assign m_awaddr  = wgnt ? s1_awaddr : s0_awaddr;
  assign m_awlen   = wgnt ? s1_awlen  : s0_awlen;
  assign m_awsize  = wgnt ? s1_awsize : s0_awsize;
  assign m_awburst = 2'b01;
  assign m_awlock  = 2'b00;
  assign m_awcache = 4'b0000;
  assign m_awprot  = 3'b000;
  assign m_awvalid = w_addr & (wgnt ? s1_awvalid : s0_awvalid);
  assign s0_awready = w_addr & ~wgnt & m_awready;
  assign s1_awready = w_addr &  wgnt & m_awready;

  assign m_wid     = m_awid;
  assign m_wdata   = wgnt ? s1_wdata : s0_wdata;
  assign m_wstrb   = wgnt ? s1_wstrb : s0_wstrb;
  assign m_wlast   = wgnt ? s1_wlast : s0_wlast;
  assign m_wvalid  = w_data & (wgnt ? s1_wvalid : s0_wvalid);
  assign s0_wready = w_data & ~wgnt & m_wready;
  assign s1_wready = w_data &  wgnt & m_wready;

  assign s0_bresp  = m_bresp;
  assign s1_bresp  = m_bresp;
  assign s0_bvalid = w_resp & ~wgnt & m_bvalid;
  assign s1_bvalid = w_resp &  wgnt & m_bvalid;
  assign m_bready  = w_resp & (wgnt ? s1_bready : s0_bready);

endmodule

// File: tb/tb_axi_rd_wr_arbiter_2to1.sv
// Directed bench for the 2:1 AXI arbiter.
// Slave side is driven by hand; expected values are literal.
module tb_axi_rd_wr_arbiter_2to1;
  localparam int ID_W = 4;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic [31:0] s0_araddr, s1_araddr;
  logic [7:0]  s0_arlen, s1_arlen;
  logic [2:0]  s0_arsize, s1_arsize;
  logic        s0_arvalid, s1_arvalid, s0_arready, s1_arready;
  logic [31:0] s0_rdata, s1_rdata;
  logic [1:0]  s0_rresp, s1_rresp;
  logic [ID_W-1:0] s0_rid, s1_rid;
  logic        s0_rlast, s1_rlast, s0_rvalid, s1_rvalid;
  logic        s0_rready, s1_rready;
  logic [31:0] s0_awaddr, s1_awaddr;
  logic [7:0]  s0_awlen, s1_awlen;
  logic [2:0]  s0_awsize, s1_awsize;
  logic        s0_awvalid, s1_awvalid, s0_awready, s1_awready;
  logic [31:0] s0_wdata, s1_wdata;
  logic [3:0]  s0_wstrb, s1_wstrb;
  logic        s0_wlast, s1_wlast, s0_wvalid, s1_wvalid;
  logic        s0_wready, s1_wready;
  logic [1:0]  s0_bresp, s1_bresp;
  logic        s0_bvalid, s1_bvalid, s0_bready, s1_bready;

  logic [ID_W-1:0] m_arid, m_rid, m_awid, m_wid, m_bid;
  logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic [7:0]  m_arlen, m_awlen;
  logic [2:0]  m_arsize, m_awsize, m_arprot, m_awprot;
  logic [1:0]  m_arburst, m_awburst, m_arlock, m_awlock;
  logic [3:0]  m_arcache, m_awcache, m_wstrb;
  logic [1:0]  m_rresp, m_bresp;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
  logic        m_bvalid, m_bready;

  int checks = 0;
  int errors = 0;

  axi_rd_wr_arbiter_2to1 #(.ID_W(ID_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
    .s0_arsize(s0_arsize), .s0_arvalid(s0_arvalid),
    .s0_arready(s0_arready), .s0_rdata(s0_rdata),
    .s0_rresp(s0_rresp), .s0_rid(s0_rid),
    .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid),
    .s0_rready(s0_rready), .s0_awaddr(s0_awaddr),
    .s0_awlen(s0_awlen), .s0_awsize(s0_awsize),
    .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
    .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
    .s0_wlast(s0_wlast), .s0_wvalid(s0_wvalid),
    .s0_wready(s0_wready), .s0_bresp(s0_bresp),
    .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
    .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
    .s1_arsize(s1_arsize), .s1_arvalid(s1_arvalid),
    .s1_arready(s1_arready), .s1_rdata(s1_rdata),
    .s1_rresp(s1_rresp), .s1_rid(s1_rid),
    .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid),
    .s1_rready(s1_rready), .s1_awaddr(s1_awaddr),
    .s1_awlen(s1_awlen), .s1_awsize(s1_awsize),
    .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
    .s1_wlast(s1_wlast), .s1_wvalid(s1_wvalid),
    .s1_wready(s1_wready), .s1_bresp(s1_bresp),
    .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
    .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arlock(m_arlock),
    .m_arcache(m_arcache), .m_arprot(m_arprot),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awlock(m_awlock),
    .m_awcache(m_awcache), .m_awprot(m_awprot),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wid(m_wid), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp),
    .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  // Idle -> addr -> handshake; returns in the data phase.
  task automatic ar_grant(input logic eid,
                          input logic [31:0] eaddr,
                          input logic [7:0] elen);
    #1;
    chk("ar_bubble", m_arvalid, 1'b0);
    tick;
    chk("ar_valid", m_arvalid, 1'b1);
    chk("ar_id", m_arid, {3'b000, eid});
    chk("ar_addr", m_araddr, eaddr);
    chk("ar_len", m_arlen, elen);
    m_arready = 1'b1;
    #1;
    chk("ar_ready_route", {s1_arready, s0_arready},
        eid ? 2'b10 : 2'b01);
    tick;
    m_arready = 1'b0;
  endtask

  // Beats first..last_ex-1 of a total-beat burst, data base+i.
  task automatic rd_burst(input int first, input int last_ex,
                          input int total,
                          input logic [31:0] base,
                          input logic eg, input bit tog);
    int i;
    int cyc;
    logic rr;
    i = first;
    cyc = 0;
    while (i < last_ex && cyc < 64) begin
      rr = tog ? ((cyc % 2) == 1) : 1'b1;
      if (eg) s1_rready = rr;
      else s0_rready = rr;
      m_rvalid = 1'b1;
      m_rdata = base + i;
      m_rresp = 2'b00;
      m_rlast = (i == total - 1);
      #1;
      chk("r_valid_route", {s1_rvalid, s0_rvalid},
          eg ? 2'b10 : 2'b01);
      chk("r_data", eg ? s1_rdata : s0_rdata, base + i);
      chk("r_ready", m_rready, rr);
      tick;
      if (rr) i++;
      cyc++;
    end
    if (i < last_ex) chk("r_timeout", i, last_ex);
    m_rvalid = 1'b0;
    m_rlast = 1'b0;
    s0_rready = 1'b1;
    s1_rready = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {m_arvalid, m_awvalid, m_wvalid, m_rready,
              m_bready, s0_arready, s1_arready, s0_rvalid,
              s1_rvalid, s0_awready, s1_awready, s0_wready,
              s1_wready, s0_bvalid, s1_bvalid}, 15'h0);
  endtask

  initial begin
    aresetn = 1'b0;
    {s0_araddr, s0_arlen, s0_arsize, s0_arvalid} = '0;
    {s1_araddr, s1_arlen, s1_arsize, s1_arvalid} = '0;
    {s0_awaddr, s0_awlen, s0_awsize, s0_awvalid} = '0;
    {s1_awaddr, s1_awlen, s1_awsize, s1_awvalid} = '0;
    {s0_wdata, s0_wstrb, s0_wlast, s0_wvalid} = '0;
    {s1_wdata, s1_wstrb, s1_wlast, s1_wvalid} = '0;
    {s0_rready, s1_rready, s0_bready, s1_bready} = '0;
    {m_arready, m_awready, m_wready} = '0;
    {m_rid, m_rdata, m_rresp, m_rlast, m_rvalid} = '0;
    {m_bid, m_bresp, m_bvalid} = '0;
    s0_araddr = 32'h0000_1234;
    s1_araddr = 32'h0000_5678;
    m_rvalid = 1'b1;
    m_bvalid = 1'b1;
    tick;
    tick;
    // reset state
    chk_all_zero("reset_zero");
    chk("reset_ids", {m_arid, m_awid, m_wid}, 12'h0);
    chk("reset_mux_p0", m_araddr, 32'h0000_1234);
    chk("burst_const", {m_arburst, m_awburst}, 4'b0101);
    aresetn = 1'b1;
    m_rvalid = 1'b0;
    m_bvalid = 1'b0;
    s0_rready = 1'b1;
    s1_rready = 1'b1;
    s0_bready = 1'b1;
    s1_bready = 1'b1;
    tick;

    // single icache read, 8 beats
    s0_araddr = 32'h1FC0_0000;
    s0_arlen = 8'd7;
    s0_arsize = 3'd2;
    s0_arvalid = 1'b1;
    ar_grant(1'b0, 32'h1FC0_0000, 8'd7);
    s0_arvalid = 1'b0;
    rd_burst(0, 8, 8, 32'hA000_0000, 1'b0, 1'b0);
    m_rvalid = 1'b1;
    #1;
    chk("stray_r_valid", {s1_rvalid, s0_rvalid}, 2'b00);
    chk("stray_r_ready", m_rready, 1'b0);
    m_rvalid = 1'b0;

    // tie right after reset: s1, s0, s1, s0
    aresetn = 1'b0;
    tick;
    aresetn = 1'b1;
    tick;
    s0_araddr = 32'h0000_0100;
    s1_araddr = 32'h0000_0200;
    s0_arlen = 8'd0;
    s1_arlen = 8'd0;
    s0_arvalid = 1'b1;
    s1_arvalid = 1'b1;
    ar_grant(1'b1, 32'h0000_0200, 8'd0);
    rd_burst(0, 1, 1, 32'hB000_0000, 1'b1, 1'b0);
    ar_grant(1'b0, 32'h0000_0100, 8'd0);
    rd_burst(0, 1, 1, 32'hC000_0000, 1'b0, 1'b0);
    ar_grant(1'b1, 32'h0000_0200, 8'd0);
    rd_burst(0, 1, 1, 32'hB100_0000, 1'b1, 1'b0);
    ar_grant(1'b0, 32'h0000_0100, 8'd0);
    s0_arvalid = 1'b0;
    s1_arvalid = 1'b0;
    rd_burst(0, 1, 1, 32'hC100_0000, 1'b0, 1'b0);

    // s0 read overlapping s1 single write
    s0_araddr = 32'h1FC0_0100;
    s0_arlen = 8'd7;
    s0_arvalid = 1'b1;
    s1_awaddr = 32'h8000_0010;
    s1_awlen = 8'd0;
    s1_awsize = 3'd2;
    s1_awvalid = 1'b1;
    s1_wdata = 32'hDEAD_BEEF;
    s1_wstrb = 4'b0011;
    s1_wlast = 1'b1;
    s1_wvalid = 1'b1;
    #1;
    chk("cc_idle", {m_arvalid, m_awvalid}, 2'b00);
    tick;
    chk("cc_ar_id", {m_arvalid, m_arid}, 5'b1_0000);
    chk("cc_aw_id", {m_awvalid, m_awid}, 5'b1_0001);
    chk("cc_aw_addr", m_awaddr, 32'h8000_0010);
    m_arready = 1'b1;
    m_awready = 1'b1;
    #1;
    chk("cc_readies", {s0_arready, s1_awready, s0_awready},
        3'b110);
    tick;
    s0_arvalid = 1'b0;
    s1_awvalid = 1'b0;
    m_arready = 1'b0;
    m_awready = 1'b0;
    m_wready = 1'b1;
    m_rvalid = 1'b1;
    m_rdata = 32'hD000_0000;
    m_rlast = 1'b0;
    #1;
    chk("cc_r0", {s0_rvalid, s0_rdata}, {1'b1, 32'hD000_0000});
    chk("cc_w_data", m_wdata, 32'hDEAD_BEEF);
    chk("cc_w_ctl", {m_wvalid, m_wstrb, m_wlast, m_wid},
        {1'b1, 4'b0011, 1'b1, 4'd1});
    chk("cc_w_ready", {s1_wready, s0_wready}, 2'b10);
    tick;
    s1_wvalid = 1'b0;
    m_wready = 1'b0;
    m_bvalid = 1'b1;
    m_bresp = 2'b00;
    m_rdata = 32'hD000_0001;
    #1;
    chk("cc_b", {s1_bvalid, s0_bvalid, m_bready}, 3'b101);
    chk("cc_r1", {s0_rvalid, s0_rdata}, {1'b1, 32'hD000_0001});
    tick;
    m_bvalid = 1'b0;
    #1;
    chk("cc_b_done", s1_bvalid, 1'b0);
    rd_burst(2, 8, 8, 32'hD000_0000, 1'b0, 1'b0);

    // W presented 3 cycles before AW
    s1_wdata = 32'h1234_5678;
    s1_wstrb = 4'hF;
    s1_wlast = 1'b1;
    s1_wvalid = 1'b1;
    m_wready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("wfirst_hold", {s1_wready, m_wvalid}, 2'b00);
      tick;
    end
    s1_awaddr = 32'h8000_0020;
    s1_awvalid = 1'b1;
    #1;
    chk("wfirst_aw_idle", m_awvalid, 1'b0);
    tick;
    chk("wfirst_aw", {m_awvalid, s1_wready}, 2'b10);
    m_awready = 1'b1;
    #1;
    chk("wfirst_awready", s1_awready, 1'b1);
    tick;
    s1_awvalid = 1'b0;
    m_awready = 1'b0;
    #1;
    chk("wfirst_beat", {s1_wready, m_wvalid, m_wlast}, 3'b111);
    chk("wfirst_data", m_wdata, 32'h1234_5678);
    tick;
    s1_wvalid = 1'b0;
    m_wready = 1'b0;
    m_bvalid = 1'b1;
    m_bresp = 2'b10;
    #1;
    chk("wfirst_b", {s1_wready, s1_bvalid, s1_bresp, m_bready},
        5'b0_1_10_1);
    tick;
    #1;
    chk("stray_b", {s1_bvalid, m_bready}, 2'b00);
    m_bvalid = 1'b0;

    // AR backpressure and toggling rready
    s0_araddr = 32'h0000_2000;
    s0_arlen = 8'd3;
    s0_arvalid = 1'b1;
    #1;
    chk("bp_idle", m_arvalid, 1'b0);
    tick;
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold", {m_arvalid, s0_arready}, 2'b10);
      tick;
    end
    m_arready = 1'b1;
    #1;
    chk("bp_accept", s0_arready, 1'b1);
    tick;
    s0_arvalid = 1'b0;
    m_arready = 1'b0;
    rd_burst(0, 4, 4, 32'h3000_0000, 1'b0, 1'b1);

    // reset at beat 3 of 8, then a fresh read
    s0_araddr = 32'h1FC0_0200;
    s0_arlen = 8'd7;
    s0_arvalid = 1'b1;
    ar_grant(1'b0, 32'h1FC0_0200, 8'd7);
    s0_arvalid = 1'b0;
    rd_burst(0, 3, 8, 32'h5000_0000, 1'b0, 1'b0);
    m_rvalid = 1'b1;
    m_rdata = 32'h5000_0003;
    #1;
    chk("mid_beat3", s0_rvalid, 1'b1);
    aresetn = 1'b0;
    #1;
    chk_all_zero("mid_reset_zero");
    m_rvalid = 1'b0;
    tick;
    tick;
    aresetn = 1'b1;
    #1;
    chk_all_zero("post_reset_zero");
    chk("post_reset_ids", {m_arid, m_awid}, 8'h0);
    tick;
    s0_araddr = 32'h1FC0_0000;
    s0_arvalid = 1'b1;
    ar_grant(1'b0, 32'h1FC0_0000, 8'd7);
    s0_arvalid = 1'b0;
    rd_burst(0, 8, 8, 32'h6000_0000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
